test_data_source_mc: RTL and testbench
======================================

# test_data_source_mc

Multi-channel, parametrised test-pattern generator. Drives NUM_CH independent AXI-Stream master channels with counter, PRBS, constant or walking-one data, in fixed-length bursts or continuously, honouring per-channel backpressure. Sits behind the team's AXI-lite register front-end, which drives its simple register port, and feeds DUT inputs or capture FIFOs for loopback and link testing.

## Interface
- DATA_WIDTH, 32, stream word width; must be at least 8.
- NUM_CH, 4, number of stream channels, 1..8.
- CFG_ADDR_WIDTH, 4, register word-address width.
- axi_clk  in  1  sole clock.
- axi_resetn  in  1  reset, asynchronous, active-low.
- cfg_wr_en  in  1  register write strobe.
- cfg_wr_addr  in  CFG_ADDR_WIDTH  write word address.
- cfg_wr_data  in  32  write data.
- cfg_rd_addr  in  CFG_ADDR_WIDTH  read word address.
- cfg_rd_data  out  32  read data, registered.
- m_tdata  out  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- m_tvalid  out  NUM_CH  per-channel valid.
- m_tlast  out  NUM_CH  per-channel last beat of a burst.
- m_tready  in  NUM_CH  per-channel ready.
- busy  out  NUM_CH  channel in RUN.

## Operation
- Registers (word address):
  - 0x0 CTRL: bit0 START (write-1 pulse, reads 0); bit1 STOP (write-1 pulse, reads 0); bits[8+NUM_CH-1:8] channel enable mask.
  - 0x1 MODE[1:0]: 0 counter, 1 PRBS, 2 constant, 3 walking-one.
  - 0x2 SEED: low DATA_WIDTH bits are used.
  - 0x3 BURST_LEN: 0 means continuous.
  - 0x4 STATUS (RO): bits[NUM_CH-1:0] busy; bits[8+NUM_CH-1:8] sticky done, cleared by START.
  - 0x7 THROTTLE (see Configuration).
  - 0x8+c BEATS_c (RO): count of accepted beats since the last START, saturating at 0xFFFFFFFF.
  - Unmapped addresses read 0; writes to them are ignored.
- Per-channel FSM:
  - IDLE to RUN on START when the channel's enable bit is set. MODE, SEED, BURST_LEN and THROTTLE are shadowed at that edge, so later writes do not affect a running burst.
  - RUN to IDLE after the handshake of the final beat; done is set on the same edge.
- Initial word for channel c:
  - counter: SEED+c.
  - PRBS: SEED^c, with 1 substituted if the result is 0.
  - constant: SEED.
  - walking-one: 1 << (c mod DATA_WIDTH).
- Next word, advanced only on handshake (tvalid and tready):
  - counter: +1, modulo 2^DATA_WIDTH.
  - PRBS: shift left, bit0 = x[DW-1]^x[DW-2]^x[DW-4]^x[DW-5].
  - constant: unchanged.
  - walking-one: rotate left by 1.
- Bursts: tlast is set on beat BURST_LEN-1, counting from 0. With BURST_LEN=0, tlast stays 0.
- STOP on a channel in RUN:
  - The next handshake is the final beat and carries tlast=1. Beats already presented are never withdrawn.
  - STOP on an IDLE channel is ignored.
- START while a channel is in RUN is ignored for that channel.
- START and STOP in the same write: STOP wins, and no channel starts.
- Reset mid-operation: all channels go to IDLE immediately. tvalid drops asynchronously, violating the stream rule; this is accepted only at reset.

## Timing
- Reset values:
  - m_tvalid, m_tlast, m_tdata, busy and cfg_rd_data are 0.
  - All registers are 0, including an enable mask of 0.
  - BEATS counters are 0.
- Read latency: cfg_rd_data is valid one cycle after cfg_rd_addr is sampled.
- START written at edge N: busy and tvalid are high from N+1, with the first word on tdata.
- Handshake at edge N: the next word appears from N+1. With tready held high, one beat is accepted per cycle.
- Final handshake at edge N: tvalid, tlast and busy are 0 from N+1.
- tvalid, tdata and tlast are held stable while tready is low.

## Configuration
- Macro TEST_DATA_SOURCE_MC_THROTTLE_EN.
- Defined:
  - THROTTLE[15:0] inserts that many cycles with tvalid=0 after each handshake before the next beat.
  - THROTTLE=0 gives back-to-back beats.
- Undefined:
  - THROTTLE reads 0 and writes to it are ignored.
  - Beats are always back-to-back when tready is high.

## Test plan
- Counter burst: mode 0, SEED=0xFFFFFFFE, BURST_LEN=4, mask=0x1, tready=1 -> ch0 emits 0xFFFFFFFE, 0xFFFFFFFF, 0, 1 with tlast on the 4th beat; done0=1; BEATS_0=4.
- Backpressure: tready toggling 1,0,0,1 on all 4 channels, mode 3, BURST_LEN=3 -> data is held while ready is low; channel c emits 1<<c, 1<<(c+1), 1<<(c+2).
- PRBS seed zero: mode 1, SEED=0 -> ch0 first word is 1, second is 2; ch1 first word is 1 (0^1).
- Continuous then STOP: BURST_LEN=0, tready=0, then STOP -> the pending beat is held; after tready=1 it is accepted with tlast=1; tvalid is 0 the next cycle.
- Simultaneous START+STOP, and START while running -> no channel starts; a running channel's burst continues unchanged.
- With TEST_DATA_SOURCE_MC_THROTTLE_EN and THROTTLE=2, tready=1 -> a beat is presented every 3rd cycle. Without the macro, reading 0x7 returns 0.

Source files
------------

// File: rtl/test_data_source_mc_if.sv
// Register port and stream bundle for test_data_source_mc.
// master: the generator side (drives streams, read data, busy).
// slave:  the consumer / register front-end side.
interface test_data_source_mc_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CFG_ADDR_WIDTH = 4
);
    logic                           cfg_wr_en;
    logic [CFG_ADDR_WIDTH-1:0]      cfg_wr_addr;
    logic [31:0]                    cfg_wr_data;
    logic [CFG_ADDR_WIDTH-1:0]      cfg_rd_addr;
    logic [31:0]                    cfg_rd_data;
    logic [NUM_CH*DATA_WIDTH-1:0]   m_tdata;
    logic [NUM_CH-1:0]              m_tvalid;
    logic [NUM_CH-1:0]              m_tlast;
    logic [NUM_CH-1:0]              m_tready;
    logic [NUM_CH-1:0]              busy;

    modport master (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_addr, m_tready,
        output cfg_rd_data, m_tdata, m_tvalid, m_tlast, busy
    );

    modport slave (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_addr, m_tready,
        input  cfg_rd_data, m_tdata, m_tvalid, m_tlast, busy
    );
endinterface

// File: rtl/test_data_source_mc.sv
// test_data_source_mc: NUM_CH independent AXI-Stream pattern generators (counter, PRBS,
// constant, walking-one) in fixed-length bursts or continuous, behind a simple register port.
// Optional macro TEST_DATA_SOURCE_MC_THROTTLE_EN enables the THROTTLE register, which
// inserts idle cycles after each handshake. Without it THROTTLE reads 0.
// START clears the sticky done bit only of the channels it actually starts.
module test_data_source_mc #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CFG_ADDR_WIDTH = 4
) (
    input  logic                  axi_clk,
    input  logic                  axi_resetn,
    test_data_source_mc_if.master bus
);
    typedef enum logic {StIdle, StRun} ch_state_e;

    localparam logic [CFG_ADDR_WIDTH-1:0] AddrCtrl   = CFG_ADDR_WIDTH'(0);
    localparam logic [CFG_ADDR_WIDTH-1:0] AddrMode   = CFG_ADDR_WIDTH'(1);
    localparam logic [CFG_ADDR_WIDTH-1:0] AddrSeed   = CFG_ADDR_WIDTH'(2);
    localparam logic [CFG_ADDR_WIDTH-1:0] AddrLen    = CFG_ADDR_WIDTH'(3);
    localparam logic [CFG_ADDR_WIDTH-1:0] AddrStatus = CFG_ADDR_WIDTH'(4);
    localparam logic [CFG_ADDR_WIDTH-1:0] AddrThr    = CFG_ADDR_WIDTH'(7);

    // Global configuration registers
    logic [NUM_CH-1:0]     r_mask;
    logic [1:0]            r_mode;
    logic [31:0]           r_seed;
    logic [31:0]           r_burst_len;
`ifdef TEST_DATA_SOURCE_MC_THROTTLE_EN
    logic [15:0]           r_throttle;
`endif
    logic [31:0]           r_rd_data;

    // Per-channel state and shadowed configuration
    ch_state_e             r_state   [NUM_CH];
    logic [NUM_CH-1:0]     r_valid;
    logic [NUM_CH-1:0]     r_stop;
    logic [NUM_CH-1:0]     r_done;
    logic [DATA_WIDTH-1:0] r_data    [NUM_CH];
    logic [31:0]           r_cnt     [NUM_CH];
    logic [31:0]           r_len     [NUM_CH];
    logic [31:0]           r_beats   [NUM_CH];
    logic [1:0]            r_ch_mode [NUM_CH];
    logic [15:0]           r_ch_thr  [NUM_CH];
    logic [15:0]           r_gap     [NUM_CH];

    logic                  w_ctrl_wr;
    logic                  w_start_wr;
    logic                  w_stop_wr;
    logic                  w_start_go;
    logic [NUM_CH-1:0]     w_start_mask;
    logic [15:0]           w_thr_cfg;
    logic [DATA_WIDTH-1:0] w_seed;
    logic [DATA_WIDTH-1:0] w_xor     [NUM_CH];
    logic [DATA_WIDTH-1:0] w_init    [NUM_CH];
    logic [DATA_WIDTH-1:0] w_next    [NUM_CH];
    logic [NUM_CH-1:0]     w_busy;
    logic [NUM_CH-1:0]     w_hs;
    logic [NUM_CH-1:0]     w_last;
    logic [31:0]           w_rd;

    // Decode START/STOP pulses; a CTRL write starts channels under its own new mask
    always_comb begin
        w_ctrl_wr    = bus.cfg_wr_en && (bus.cfg_wr_addr == AddrCtrl);
        w_start_wr   = w_ctrl_wr && bus.cfg_wr_data[0];
        w_stop_wr    = w_ctrl_wr && bus.cfg_wr_data[1];
        w_start_go   = w_start_wr && !w_stop_wr;
        w_start_mask = w_ctrl_wr ? bus.cfg_wr_data[8 +: NUM_CH] : r_mask;
        w_seed       = DATA_WIDTH'(r_seed);
`ifdef TEST_DATA_SOURCE_MC_THROTTLE_EN
        w_thr_cfg    = r_throttle;
`else
        w_thr_cfg    = 16'd0;
`endif
    end

    // Per-channel initial word, next word, handshake and last-beat flags
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_busy[c] = (r_state[c] == StRun);
            w_hs[c]   = r_valid[c] && bus.m_tready[c];
            w_last[c] = r_valid[c] && (r_stop[c] ||
                        ((r_len[c] != 32'd0) && (r_cnt[c] == r_len[c] - 32'd1)));
            w_xor[c]  = w_seed ^ DATA_WIDTH'(c);
            case (r_mode)
                2'd0:    w_init[c] = w_seed + DATA_WIDTH'(c);
                2'd1:    w_init[c] = (w_xor[c] == '0) ? DATA_WIDTH'(1) : w_xor[c];
                2'd2:    w_init[c] = w_seed;
                default: w_init[c] = DATA_WIDTH'(1) << (c % DATA_WIDTH);
            endcase
            case (r_ch_mode[c])
                2'd0:    w_next[c] = r_data[c] + DATA_WIDTH'(1);
                2'd1:    w_next[c] = {r_data[c][DATA_WIDTH-2:0],
                                      r_data[c][DATA_WIDTH-1] ^ r_data[c][DATA_WIDTH-2] ^
                                      r_data[c][DATA_WIDTH-4] ^ r_data[c][DATA_WIDTH-5]};
                2'd2:    w_next[c] = r_data[c];
                default: w_next[c] = {r_data[c][DATA_WIDTH-2:0], r_data[c][DATA_WIDTH-1]};
            endcase
        end
    end

    // Configuration register writes; CTRL keeps only the enable mask
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_mask      <= '0;
            r_mode      <= '0;
            r_seed      <= '0;
            r_burst_len <= '0;
`ifdef TEST_DATA_SOURCE_MC_THROTTLE_EN
            r_throttle  <= '0;
`endif
        end else if (bus.cfg_wr_en) begin
            case (bus.cfg_wr_addr)
                AddrCtrl: r_mask      <= bus.cfg_wr_data[8 +: NUM_CH];
                AddrMode: r_mode      <= bus.cfg_wr_data[1:0];
                AddrSeed: r_seed      <= bus.cfg_wr_data;
                AddrLen:  r_burst_len <= bus.cfg_wr_data;
`ifdef TEST_DATA_SOURCE_MC_THROTTLE_EN
                AddrThr:  r_throttle  <= bus.cfg_wr_data[15:0];
`endif
                default: ;
            endcase
        end
    end

    // Read mux; BEATS_c sit at 8+c, unmapped addresses return 0
    always_comb begin
        w_rd = '0;
        case (bus.cfg_rd_addr)
            AddrCtrl:   w_rd[8 +: NUM_CH] = r_mask;
            AddrMode:   w_rd[1:0]         = r_mode;
            AddrSeed:   w_rd              = r_seed;
            AddrLen:    w_rd              = r_burst_len;
            AddrStatus: begin
                w_rd[NUM_CH-1:0]  = w_busy;
                w_rd[8 +: NUM_CH] = r_done;
            end
            AddrThr:    w_rd[15:0]        = w_thr_cfg;
            default: ;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.cfg_rd_addr == CFG_ADDR_WIDTH'(8 + c)) w_rd = r_beats[c];
        end
    end

    // Registered read data
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) r_rd_data <= '0;
        else             r_rd_data <= w_rd;
    end

    // Per-channel IDLE/RUN FSM with registered valid, data and beat accounting
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_valid <= '0;
            r_stop  <= '0;
            r_done  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_state[c]   <= StIdle;
                r_data[c]    <= '0;
                r_cnt[c]     <= '0;
                r_len[c]     <= '0;
                r_beats[c]   <= '0;
                r_ch_mode[c] <= '0;
                r_ch_thr[c]  <= '0;
                r_gap[c]     <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                case (r_state[c])
                    StIdle: begin
                        if (w_start_go && w_start_mask[c]) begin
                            r_state[c]   <= StRun;
                            r_valid[c]   <= 1'b1;
                            r_stop[c]    <= 1'b0;
                            r_done[c]    <= 1'b0;
                            r_data[c]    <= w_init[c];
                            r_cnt[c]     <= '0;
                            r_beats[c]   <= '0;
                            r_len[c]     <= r_burst_len;
                            r_ch_mode[c] <= r_mode;
                            r_ch_thr[c]  <= w_thr_cfg;
                            r_gap[c]     <= '0;
                        end
                    end
                    default: begin
                        if (w_stop_wr) r_stop[c] <= 1'b1;
                        if (w_hs[c]) begin
                            if (r_beats[c] != 32'hFFFF_FFFF) r_beats[c] <= r_beats[c] + 32'd1;
                            if (w_last[c]) begin
                                r_state[c] <= StIdle;
                                r_valid[c] <= 1'b0;
                                r_stop[c]  <= 1'b0;
                                r_done[c]  <= 1'b1;
                            end else begin
                                r_data[c] <= w_next[c];
                                r_cnt[c]  <= r_cnt[c] + 32'd1;
                                if (r_ch_thr[c] != 16'd0) begin
                                    r_valid[c] <= 1'b0;
                                    r_gap[c]   <= r_ch_thr[c];
                                end
                            end
                        end else if (!r_valid[c]) begin
                            // Idle gap: re-present the next beat when the count expires
                            if (r_gap[c] <= 16'd1) r_valid[c] <= 1'b1;
                            r_gap[c] <= (r_gap[c] == 16'd0) ? 16'd0 : r_gap[c] - 16'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.m_tvalid    = r_valid;
    assign bus.m_tlast     = w_last;
    assign bus.busy        = w_busy;
    assign bus.cfg_rd_data = r_rd_data;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_tdata
        assign bus.m_tdata[g*DATA_WIDTH +: DATA_WIDTH] = r_data[g];
    end
endmodule

// File: tb/tb_test_data_source_mc.sv
// Scoreboard bench for test_data_source_mc: directed stimulus pushes expected beats per
// channel; an independent negedge monitor pops and compares on every handshake.
module tb_test_data_source_mc;
    localparam int unsigned DW  = 32;
    localparam int unsigned NCH = 4;
    localparam int unsigned AW  = 4;
`ifdef TEST_DATA_SOURCE_MC_THROTTLE_EN
    localparam int unsigned ThrGap = 3;
    localparam logic [31:0] ThrRead = 32'd2;
`else
    localparam int unsigned ThrGap = 1;
    localparam logic [31:0] ThrRead = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [DW:0]       exp_q [NCH][$];
    logic [NCH-1:0]    stall_q = '0;
    logic [DW-1:0]     prev_data [NCH];

    test_data_source_mc_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CFG_ADDR_WIDTH(AW)) u_if ();

    test_data_source_mc #(
        .DATA_WIDTH    (DW),
        .NUM_CH        (NCH),
        .CFG_ADDR_WIDTH(AW)
    ) u_dut (
        .axi_clk   (clk),
        .axi_resetn(rst_n),
        .bus       (u_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: compare every handshake against the scoreboard, and check stalled beats hold
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                automatic logic [DW-1:0] d = u_if.m_tdata[c*DW +: DW];
                automatic logic [DW:0]   e;
                if (stall_q[c]) begin
                    check($sformatf("hold_valid_ch%0d", c), 32'(u_if.m_tvalid[c]), 32'd1);
                    check($sformatf("hold_data_ch%0d", c), d, prev_data[c]);
                end
                if (u_if.m_tvalid[c] && u_if.m_tready[c]) begin
                    if (exp_q[c].size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_beat_ch%0d: got data 0x%08h, expected no beat",
                                 c, d);
                    end else begin
                        e = exp_q[c].pop_front();
                        check($sformatf("beat_data_ch%0d", c), d, e[DW-1:0]);
                        check($sformatf("beat_last_ch%0d", c), 32'(u_if.m_tlast[c]), 32'(e[DW]));
                    end
                end
                stall_q[c]   <= u_if.m_tvalid[c] && !u_if.m_tready[c];
                prev_data[c] <= d;
            end
        end else begin
            stall_q <= '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [DW-1:0] d, input logic last);
        exp_q[c].push_back({last, d});
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [31:0] d);
        u_if.cfg_wr_en   = 1'b1;
        u_if.cfg_wr_addr = a;
        u_if.cfg_wr_data = d;
        tick();
        u_if.cfg_wr_en   = 1'b0;
    endtask

    task automatic cfg_read(input string name, input logic [AW-1:0] a, input logic [31:0] msk,
                            input logic [31:0] req);
        u_if.cfg_rd_addr = a;
        tick();
        check(name, u_if.cfg_rd_data & msk, req);
    endtask

    function automatic bit all_empty();
        for (int c = 0; c < NCH; c++) if (exp_q[c].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((u_if.busy != '0 || !all_empty()) && n < 300) begin
            tick();
            n++;
        end
        check({name, "_idle_busy"}, 32'(u_if.busy), 32'd0);
        check({name, "_idle_pending"}, 32'(all_empty()), 32'd1);
    endtask

    initial begin
        int hs[$];
        logic [3:0] pat;
        u_if.cfg_wr_en   = 1'b0;
        u_if.cfg_wr_addr = '0;
        u_if.cfg_wr_data = '0;
        u_if.cfg_rd_addr = '0;
        u_if.m_tready    = '0;
        repeat (3) tick();

        // Reset values
        check("rst_tvalid", 32'(u_if.m_tvalid), 32'd0);
        check("rst_tlast", 32'(u_if.m_tlast), 32'd0);
        check("rst_tdata", u_if.m_tdata[31:0], 32'd0);
        check("rst_busy", 32'(u_if.busy), 32'd0);
        check("rst_rd_data", u_if.cfg_rd_data, 32'd0);
        rst_n = 1'b1;
        tick();
        cfg_read("rst_ctrl", 4'h0, 32'hFFFF_FFFF, 32'd0);
        cfg_read("rst_status", 4'h4, 32'hFFFF_FFFF, 32'd0);
        cfg_read("rst_beats0", 4'h8, 32'hFFFF_FFFF, 32'd0);

        // Counter burst with wrap
        u_if.m_tready = '1;
        cfg_write(4'h1, 32'd0);
        cfg_write(4'h2, 32'hFFFF_FFFE);
        cfg_write(4'h3, 32'd4);
        cfg_read("seed_readback", 4'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        push(0, 32'hFFFF_FFFE, 1'b0);
        push(0, 32'hFFFF_FFFF, 1'b0);
        push(0, 32'h0000_0000, 1'b0);
        push(0, 32'h0000_0001, 1'b1);
        cfg_write(4'h0, 32'h0000_0101);
        check("cnt_busy_after_start", 32'(u_if.busy), 32'h1);
        wait_idle("cnt");
        cfg_read("cnt_status", 4'h4, 32'hFFFF_FFFF, 32'h0000_0100);
        cfg_read("cnt_beats0", 4'h8, 32'hFFFF_FFFF, 32'd4);
        cfg_read("cnt_beats1", 4'h9, 32'hFFFF_FFFF, 32'd0);
        cfg_read("cnt_ctrl_mask", 4'h0, 32'hFFFF_FFFF, 32'h0000_0100);

        // Walking-one with toggling backpressure on all channels
        cfg_write(4'h1, 32'd3);
        cfg_write(4'h3, 32'd3);
        for (int c = 0; c < NCH; c++) begin
            push(c, 32'h1 << c, 1'b0);
            push(c, 32'h1 << (c + 1), 1'b0);
            push(c, 32'h1 << (c + 2), 1'b1);
        end
        u_if.m_tready = '0;
        cfg_write(4'h0, 32'h0000_0F01);
        pat = 4'b1001;
        for (int i = 0; i < 40; i++) begin
            u_if.m_tready = pat[i % 4] ? '1 : '0;
            tick();
        end
        u_if.m_tready = '1;
        wait_idle("walk");

        // PRBS with zero seed
        cfg_write(4'h1, 32'd1);
        cfg_write(4'h2, 32'd0);
        cfg_write(4'h3, 32'd2);
        push(0, 32'd1, 1'b0);
        push(0, 32'd2, 1'b1);
        push(1, 32'd1, 1'b0);
        push(1, 32'd2, 1'b1);
        cfg_write(4'h0, 32'h0000_0301);
        wait_idle("prbs");

        // Continuous constant, stalled, then STOP
        u_if.m_tready = '0;
        cfg_write(4'h1, 32'd2);
        cfg_write(4'h2, 32'hA5A5_0001);
        cfg_write(4'h3, 32'd0);
        cfg_write(4'h0, 32'h0000_0101);
        repeat (3) tick();
        check("stop_pre_valid", 32'(u_if.m_tvalid[0]), 32'd1);
        check("stop_pre_last", 32'(u_if.m_tlast[0]), 32'd0);
        check("stop_pre_data", u_if.m_tdata[31:0], 32'hA5A5_0001);
        push(0, 32'hA5A5_0001, 1'b1);
        cfg_write(4'h0, 32'h0000_0102);
        tick();
        check("stop_held_valid", 32'(u_if.m_tvalid[0]), 32'd1);
        check("stop_held_last", 32'(u_if.m_tlast[0]), 32'd1);
        u_if.m_tready = 4'b0001;
        tick();
        check("stop_post_valid", 32'(u_if.m_tvalid[0]), 32'd0);
        check("stop_post_busy", 32'(u_if.busy[0]), 32'd0);
        wait_idle("stop");
        cfg_read("stop_beats0", 4'h8, 32'hFFFF_FFFF, 32'd1);

        // START+STOP starts nothing; START while running leaves that channel alone
        u_if.m_tready = '0;
        cfg_write(4'h0, 32'h0000_0F03);
        tick();
        check("ss_busy", 32'(u_if.busy), 32'd0);
        check("ss_valid", 32'(u_if.m_tvalid), 32'd0);
        cfg_write(4'h1, 32'd0);
        cfg_write(4'h2, 32'h10);
        cfg_write(4'h3, 32'd6);
        for (int i = 0; i < 6; i++) push(0, 32'h10 + 32'(i), (i == 5));
        cfg_write(4'h0, 32'h0000_0101);
        check("rr_busy_ch0", 32'(u_if.busy), 32'h1);
        cfg_write(4'h3, 32'd2);
        cfg_write(4'h1, 32'd2);
        cfg_write(4'h2, 32'h999);
        push(1, 32'h999, 1'b0);
        push(1, 32'h999, 1'b1);
        cfg_write(4'h0, 32'h0000_0301);
        check("rr_busy_both", 32'(u_if.busy), 32'h3);
        check("rr_ch0_data", u_if.m_tdata[31:0], 32'h10);
        u_if.m_tready = '1;
        wait_idle("rr");
        cfg_read("rr_beats0", 4'h8, 32'hFFFF_FFFF, 32'd6);
        cfg_read("rr_beats1", 4'h9, 32'hFFFF_FFFF, 32'd2);
        cfg_read("rr_status", 4'h4, 32'h0000_03FF, 32'h0000_0300);

        // THROTTLE register and beat spacing; unmapped address
        cfg_write(4'h7, 32'd2);
        cfg_read("thr_read", 4'h7, 32'hFFFF_FFFF, ThrRead);
        cfg_write(4'h5, 32'hFFFF_FFFF);
        cfg_read("unmapped_read", 4'h5, 32'hFFFF_FFFF, 32'd0);
        cfg_write(4'h1, 32'd0);
        cfg_write(4'h2, 32'd0);
        cfg_write(4'h3, 32'd4);
        for (int i = 0; i < 4; i++) push(0, 32'(i), (i == 3));
        cfg_write(4'h0, 32'h0000_0101);
        for (int i = 0; i < 20; i++) begin
            if (u_if.m_tvalid[0] && u_if.m_tready[0]) hs.push_back(i);
            tick();
        end
        check("thr_beat_count", 32'(hs.size()), 32'd4);
        for (int i = 1; i < hs.size(); i++)
            check($sformatf("thr_spacing_%0d", i), 32'(hs[i] - hs[i-1]), ThrGap);
        wait_idle("thr");

        // Asynchronous reset mid-run drops valid without a clock edge
        u_if.m_tready = '0;
        cfg_write(4'h1, 32'd2);
        cfg_write(4'h3, 32'd0);
        cfg_write(4'h0, 32'h0000_0101);
        check("mid_valid_before", 32'(u_if.m_tvalid[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_valid_after_rst", 32'(u_if.m_tvalid), 32'd0);
        check("mid_busy_after_rst", 32'(u_if.busy), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        cfg_read("mid_mode_after_rst", 4'h1, 32'hFFFF_FFFF, 32'd0);
        cfg_read("mid_beats_after_rst", 4'h8, 32'hFFFF_FFFF, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
